// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the radix-4 Booth multiplier
// Purpose: FSM state encoding, Booth digit select codes and the iteration-count helper.
// Ports: none (package).
// Build option: MUL_UNSIGNED_EN adds unsigned operand support (one extra Booth digit).
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth digit select codes, bit order {neg, one, two}.
  localparam logic [2:0] SEL_ZERO = 3'b000;
  localparam logic [2:0] SEL_POS1 = 3'b010;
  localparam logic [2:0] SEL_POS2 = 3'b001;
  localparam logic [2:0] SEL_NEG1 = 3'b110;
  localparam logic [2:0] SEL_NEG2 = 3'b101;

  // Number of Booth digits retired per multiply. The unsigned-capable build
  // widens the multiplier by two bits so a zero-extended operand still has a
  // sign digit, which costs one more iteration in both modes.
  function automatic int iter_count(input int width);
`ifdef MUL_UNSIGNED_EN
    return width / 2 + 1;
`else
    return width / 2;
`endif
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - radix-4 Booth digit encoder
// Purpose: maps the 3-bit multiplier window {b[1], b[0], q_-1} to a partial-product select.
// Ports:
//   window  in   3  Booth window {b[1], b[0], q_-1}
//   neg     out  1  negate the selected multiple
//   one     out  1  select 1 x multiplicand
//   two     out  1  select 2 x multiplicand
module booth_r4_encoder
  import mul_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       one,
  output logic       two
);

  logic [2:0] sel;

  always_comb begin
    sel = SEL_ZERO;
    case (window)
      3'b000:  sel = SEL_ZERO;
      3'b001:  sel = SEL_POS1;
      3'b010:  sel = SEL_POS1;
      3'b011:  sel = SEL_POS2;
      3'b100:  sel = SEL_NEG2;
      3'b101:  sel = SEL_NEG1;
      3'b110:  sel = SEL_NEG1;
      3'b111:  sel = SEL_ZERO;
      default: sel = SEL_ZERO;
    endcase
  end

  assign {neg, one, two} = sel;

endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-4 Booth multiplier, one digit per clock
// Purpose: exact 2*WIDTH-bit two's-complement product behind a start/busy/done handshake.
// Ports:
//   clock         in   1      system clock
//   clear         in   1      synchronous active-high reset; aborts an in-flight multiply
//   is_unsigned   in   1      (MUL_UNSIGNED_EN only) treat both operands as unsigned
//   start         in   1      request; accepted only in IDLE or DONE
//   multiplicand  in   WIDTH  operand A, captured on accepted start
//   multiplier    in   WIDTH  operand B, captured on accepted start
//   busy          out  1      iterating
//   done          out  1      product valid; held until next accepted start or clear
//   hi            out  WIDTH  upper half of the product
//   lo            out  WIDTH  lower half of the product
// Build option: MUL_UNSIGNED_EN adds is_unsigned and runs WIDTH/2+1 iterations.
module booth_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
`ifdef MUL_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITER = iter_count(WIDTH);
  localparam int CW   = $clog2(ITER) + 1;
  localparam int AW   = WIDTH + 2;   // accumulator P and extended multiplicand
  localparam int SW   = WIDTH + 3;   // pre-shift sum, one guard bit above P
`ifdef MUL_UNSIGNED_EN
  localparam int BW   = WIDTH + 2;   // multiplier extended so unsigned values keep a sign digit
`else
  localparam int BW   = WIDTH;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   a_q;
  logic [AW-1:0]   p_q;
  logic [BW-1:0]   b_q;
  logic            q_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic            accept;
  logic            last;
  logic            neg, one, two;
  logic [SW-1:0]   a_ext;
  logic [SW-1:0]   mag;
  logic [SW-1:0]   addend;
  logic [SW-1:0]   sum;
  logic [AW-1:0]   nxt_p;
  logic [BW-1:0]   nxt_b;
  logic            ext_a, ext_b;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (cnt_q == CW'(ITER - 1));

`ifdef MUL_UNSIGNED_EN
  assign ext_a = is_unsigned ? 1'b0 : multiplicand[WIDTH-1];
  assign ext_b = is_unsigned ? 1'b0 : multiplier[WIDTH-1];
`else
  assign ext_a = multiplicand[WIDTH-1];
  assign ext_b = multiplier[WIDTH-1];
`endif

  booth_r4_encoder u_enc (
    .window ({b_q[1], b_q[0], q_q}),
    .neg    (neg),
    .one    (one),
    .two    (two)
  );

  // Selected multiple of A. The guard bit keeps P + 2A from wrapping when A
  // is a large zero-extended unsigned operand; after the shift the result
  // fits back into AW bits.
  always_comb begin
    a_ext  = {a_q[AW-1], a_q};
    mag    = '0;
    if (two)
      mag = {a_q, 1'b0};
    else if (one)
      mag = a_ext;
    addend = neg ? (~mag + SW'(1)) : mag;
    sum    = {p_q[AW-1], p_q} + addend;
    // Arithmetic shift of {P, B, q_-1} right by two.
    nxt_p  = {sum[SW-1], sum[SW-1:2]};
    nxt_b  = {sum[1:0], b_q[BW-1:2]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last)  state_d = DONE;
      DONE:    if (start) state_d = BUSY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= '0;
      a_q   <= '0;
      p_q   <= '0;
      b_q   <= '0;
      q_q   <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      a_q   <= {{2{ext_a}}, multiplicand};
      p_q   <= '0;
`ifdef MUL_UNSIGNED_EN
      b_q   <= {{2{ext_b}}, multiplier};
`else
      b_q   <= multiplier;
`endif
      q_q   <= 1'b0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CW'(1);
      p_q   <= nxt_p;
      b_q   <= nxt_b;
      q_q   <= b_q[1];
      if (last) begin
        // Low 2*WIDTH bits of {P, B} after the final shift hold the product.
`ifdef MUL_UNSIGNED_EN
        hi_q <= {nxt_p[WIDTH-3:0], nxt_b[WIDTH+1:WIDTH]};
        lo_q <= nxt_b[WIDTH-1:0];
`else
        hi_q <= nxt_p[WIDTH-1:0];
        lo_q <= nxt_b;
`endif
      end
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // ext_b is only consumed by the capture path in the wide build.
`ifndef MUL_UNSIGNED_EN
  logic unused_ext_b;
  assign unused_ext_b = ext_b;
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - self-checking bench for booth_seq_multiplier
module tb_booth_seq_multiplier;

`ifdef MUL_UNSIGNED_EN
  localparam int ITER  = 17;
  localparam int ITER8 = 5;
  localparam bit UNS_BUILD = 1'b1;
`else
  localparam int ITER  = 16;
  localparam int ITER8 = 4;
  localparam bit UNS_BUILD = 1'b0;
`endif

  logic        clock;
  logic        clear;
  logic        start, is_uns;
  logic [31:0] mcand, mplier, hi, lo;
  logic        busy, done;
  logic        start8, is_uns8;
  logic [7:0]  mcand8, mplier8, hi8, lo8;
  logic        busy8, done8;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  booth_seq_multiplier #(.WIDTH(32)) dut (
    .clock        (clock),
    .clear        (clear),
`ifdef MUL_UNSIGNED_EN
    .is_unsigned  (is_uns),
`endif
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clock        (clock),
    .clear        (clear),
`ifdef MUL_UNSIGNED_EN
    .is_unsigned  (is_uns8),
`endif
    .start        (start8),
    .multiplicand (mcand8),
    .multiplier   (mplier8),
    .busy         (busy8),
    .done         (done8),
    .hi           (hi8),
    .lo           (lo8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic uns);
    logic signed [63:0] sa, sb;
    if (uns)
      return {32'b0, a} * {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic uns);
    logic signed [15:0] sa, sb;
    if (uns)
      return {8'b0, a} * {8'b0, b};
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return sa * sb;
  endfunction

  // Drives one accepted start (edge k) and queues the expected product.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic uns);
    mcand  = a;
    mplier = b;
    is_uns = uns;
    start  = 1'b1;
    exp_q.push_back(model32(a, b, uns & UNS_BUILD));
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_on_accept", busy, 1);
  endtask

  // Waits for done, checking latency, busy coverage and the queued product.
  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    int busy_n = 0;
    logic [63:0] exp;
    while (!done && n < lat + 8) begin
      @(posedge clock);
      #1;
      n++;
      if (busy) busy_n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, busy_n, lat - 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    check({tag, "_product"}, {hi, lo}, exp);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic uns);
    int n = 0;
    mcand8  = a;
    mplier8 = b;
    is_uns8 = uns;
    start8  = 1'b1;
    @(posedge clock);
    #1;
    start8 = 1'b0;
    while (!done8 && n < ITER8 + 8) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, ITER8);
    check({tag, "_product"}, {hi8, lo8}, model8(a, b, uns & UNS_BUILD));
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; is_uns = 1'b0; mcand = '0; mplier = '0;
    start8 = 1'b0; is_uns8 = 1'b0; mcand8 = '0; mplier8 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    clear = 1'b0;

    // -5 * 25
    start_op(32'hFFFF_FFFB, 32'd25, 1'b0);
    wait_done("t1", ITER);
    check("t1_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FF83);
    repeat (3) @(posedge clock);
    #1;
    check("t1_done_held", done, 1);
    check("t1_result_held", {hi, lo}, 64'hFFFF_FFFF_FFFF_FF83);

    // Extremes, back-to-back from DONE
    start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done("t2_min", ITER);
    check("t2_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
    start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    wait_done("t2_max", ITER);
    check("t2_max_const", {hi, lo}, 64'h3FFF_FFFF_0000_0001);

    // Start while busy is ignored
    start_op(32'd30, 32'd25, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    mcand = 32'd7; mplier = 32'd7; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("t3_ignore", ITER - 5);
    check("t3_const", {hi, lo}, 64'd750);
    start_op(32'd7, 32'd7, 1'b0);
    check("t3_old_result_kept", {hi, lo}, 64'd750);
    wait_done("t3_again", ITER);
    check("t3_again_const", {hi, lo}, 64'd49);

    // clear mid-multiply
    start_op(32'd123, 32'd456, 1'b0);
    repeat (7) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_hi", hi, 0);
    check("t4_lo", lo, 0);
    void'(exp_q.pop_back());
    start_op(32'd1000, 32'hFFFF_FFFD, 1'b0);
    wait_done("t4_restart", ITER);

`ifdef MUL_UNSIGNED_EN
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("t5_uns", ITER);
    check("t5_uns_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("t5_sgn", ITER);
    check("t5_sgn_const", {hi, lo}, 64'h0000_0000_0000_0001);
`endif

    // Narrow instance
    run8("t6_corner", 8'h80, 8'h7F, 1'b0);
    check("t6_corner_const", {hi8, lo8}, 64'hC080);
    for (int i = 0; i < 200; i++)
      run8("t6_rand", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // Random sweep on the 32-bit instance
    for (int i = 0; i < 1000; i++) begin
      start_op($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done("rand", ITER);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
